ex_fwd_stage: RTL and testbench
===============================

EX_FWD_STAGE -- requirements
Module: ex_fwd_stage

Interface
REQ-001 Parameter DW, default 32: datapath width of operands and forwarded data.
REQ-002 Parameter NSRC, default 2, legal 1..4: number of forwarding sources; index 0 is the nearest stage (MEM), index NSRC-1 the oldest (WB and beyond).
REQ-003 Parameter AW, default 5: register-address width.
REQ-004 Parameter CW, default 16: stall-counter width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 id_valid  in  1  the ID stage presents an instruction.
REQ-008 id_ready  out  1  this block accepts the ID instruction this cycle.
REQ-009 id_rs, id_rt  in  AW each  source register addresses.
REQ-010 id_rs_data, id_rt_data  in  DW each  register-file read data.
REQ-011 id_wreg  in  AW  destination register; id_regwrite  in  1; id_memread  in  1.
REQ-012 fwd_we  in  NSRC  per-source register-write enable.
REQ-013 fwd_addr  in  NSRC*AW  per-source destination address; source i occupies bits [i*AW +: AW].
REQ-014 fwd_data  in  NSRC*DW  per-source result; source i occupies bits [i*DW +: DW].
REQ-015 fwd_pend  in  NSRC  per-source flag: data not yet available (load in flight).
REQ-016 ex_valid  out  1  registered output holds a valid instruction.
REQ-017 ex_ready  in  1  downstream accepts the output this cycle.
REQ-018 ex_op1, ex_op2  out  DW each  registered resolved operands.
REQ-019 ex_wreg  out  AW; ex_regwrite  out  1; ex_memread  out  1  registered copies of the ID fields.
REQ-020 ex_fwd1, ex_fwd2  out  3 each  registered select used: 0 = register file, i+1 = source i.
REQ-021 stall_cnt  out  CW  count of cycles stalled on a pending source.

Function
REQ-022 A source i matches operand X when fwd_we[i]=1, fwd_addr[i]!=0 and fwd_addr[i]=X's address.
REQ-023 Operand resolution is priority-ordered: the lowest matching index wins; with no match the register-file data is used.
REQ-024 Address 0 never matches; an operand with address 0 always resolves to id_*_data.
REQ-025 Hazard: the winning source for either operand has fwd_pend=1; a pending source at a higher index hidden behind a non-pending lower-index match raises no hazard.
REQ-026 The block has FSM states RUN and STALL; reset state is RUN.
REQ-027 RUN->STALL when id_valid=1 and a hazard exists; STALL->RUN in the first cycle with no hazard; id_ready=0 in any hazard cycle.
REQ-028 Output register load enable is load = !ex_valid | ex_ready.
REQ-029 id_ready = load & !hazard; a transfer occurs when id_valid & id_ready.
REQ-030 On a transfer with load=1, the output fields capture the resolved operands, selects and ID fields, and ex_valid becomes 1 on the next edge.
REQ-031 When load=1 and no transfer occurs, ex_valid becomes 0 (bubble) and the data fields hold their previous values.
REQ-032 When load=0 (ex_valid=1, ex_ready=0), all output fields hold and id_ready=0, whether or not a hazard exists.
REQ-033 Latency is one cycle from transfer to ex_valid; with no hazards and ex_ready held at 1, throughput is one instruction per cycle.
REQ-034 stall_cnt increments by 1 in each cycle where id_valid=1 and a hazard exists; it saturates at 2^CW-1 and does not wrap.
REQ-035 Operand resolution is combinational from the current-cycle fwd_* inputs; no forwarding state is stored.

Reset
REQ-036 rst=1 forces ex_valid=0, state=RUN, stall_cnt=0 and zero on ex_op1, ex_op2, ex_wreg, ex_regwrite, ex_memread, ex_fwd1 and ex_fwd2.
REQ-037 Reset asserted in STALL returns the FSM to RUN; the held ID instruction is not captured.
REQ-038 With rst=1, id_ready=0.
REQ-039 Reset has priority over a simultaneous transfer.

Verification
REQ-040 NSRC=2; rs=3; src0 addr=3 we=1 data=0xAAAA0000; src1 addr=3 we=1 data=0x5555 -> ex_op1=0xAAAA0000, ex_fwd1=1 one cycle later.
REQ-041 rs=0; src0 addr=0 we=1 data=0xFFFFFFFF -> ex_op1=id_rs_data, ex_fwd1=0.
REQ-042 rt=7 matches src0 with fwd_pend[0]=1 for 2 cycles, then pend=0 -> id_ready=0 for 2 cycles, stall_cnt=2, operand captured in the 3rd cycle with ex_fwd2=1.
REQ-043 ex_valid=1 and ex_ready=0 for 3 cycles with id_valid=1 -> outputs stable and id_ready=0; ex_ready=1 -> next instruction captured the following edge.
REQ-044 CW=2 with 5 hazard cycles -> stall_cnt reads 3 and stays at 3.
REQ-045 rst=1 asserted mid-STALL -> next edge: ex_valid=0, stall_cnt=0, state RUN.

Source files
------------

// File: rtl/ex_fwd_stage.sv
// ex_fwd_stage: resolves ID operands against in-flight results and registers them into the EX stage.
// Latency: one cycle from an ID transfer to ex_valid; one instruction per cycle when hazard-free.
// Backpressure: id_ready drops while a winning forward source is pending or while ex_valid is held by !ex_ready.
module ex_fwd_stage #(
    parameter int DW   = 32,
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [AW-1:0]        id_rs,
    input  logic [AW-1:0]        id_rt,
    input  logic [DW-1:0]        id_rs_data,
    input  logic [DW-1:0]        id_rt_data,
    input  logic [AW-1:0]        id_wreg,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic [NSRC-1:0]      fwd_we,
    input  logic [NSRC*AW-1:0]   fwd_addr,
    input  logic [NSRC*DW-1:0]   fwd_data,
    input  logic [NSRC-1:0]      fwd_pend,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [DW-1:0]        ex_op1,
    output logic [DW-1:0]        ex_op2,
    output logic [AW-1:0]        ex_wreg,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic [2:0]           ex_fwd1,
    output logic [2:0]           ex_fwd2,
    output logic [CW-1:0]        stall_cnt
);

    // Result of resolving one operand: chosen data, select (0 = regfile, i+1 = source i), pending flag.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    sel;
        logic          pend;
    } resolved_t;

    // Everything the EX pipeline register carries besides its valid bit.
    typedef struct packed {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [AW-1:0] wreg;
        logic          regwrite;
        logic          memread;
        logic [2:0]    fwd1;
        logic [2:0]    fwd2;
    } exFields_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Walk from the oldest source to the nearest so the lowest matching index is the last writer and wins.
    // Address 0 is hard-wired zero, so it never picks up forwarded data.
    function automatic resolved_t resolveOperand(
        input logic [AW-1:0]      addr,
        input logic [DW-1:0]      rfData,
        input logic [NSRC-1:0]    we,
        input logic [NSRC*AW-1:0] addrs,
        input logic [NSRC*DW-1:0] datas,
        input logic [NSRC-1:0]    pends
    );
        resolved_t res;
        res.data = rfData;
        res.sel  = 3'd0;
        res.pend = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (we[i] && (addrs[i*AW +: AW] != '0) && (addrs[i*AW +: AW] == addr)) begin
                res.data = datas[i*DW +: DW];
                res.sel  = 3'(i + 1);
                res.pend = pends[i];
            end
        end
        return res;
    endfunction

    resolved_t res1;
    resolved_t res2;
    exFields_t exQ;
    exFields_t exNext;
    logic      exValidQ;
    logic      hazard;
    logic      load;
    logic      idReady;
    logic      xfer;
    state_t    state;
    logic [CW-1:0] stallCntQ;

    // Forwarding is purely combinational on this cycle's source buses; a pending winner is a hazard.
    always_comb begin
        res1   = resolveOperand(id_rs, id_rs_data, fwd_we, fwd_addr, fwd_data, fwd_pend);
        res2   = resolveOperand(id_rt, id_rt_data, fwd_we, fwd_addr, fwd_data, fwd_pend);
        hazard = res1.pend | res2.pend;
        load   = ~exValidQ | ex_ready;
        idReady = load & ~hazard & ~rst;
        xfer   = id_valid & idReady;
        exNext.op1      = res1.data;
        exNext.op2      = res2.data;
        exNext.wreg     = id_wreg;
        exNext.regwrite = id_regwrite;
        exNext.memread  = id_memread;
        exNext.fwd1     = res1.sel;
        exNext.fwd2     = res2.sel;
    end

    // EX pipeline register: capture on transfer, bubble when loadable but idle, hold when blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            exValidQ <= 1'b0;
            exQ      <= '0;
        end else if (load) begin
            exValidQ <= xfer;
            if (xfer) begin
                exQ <= exNext;
            end
        end
    end

    // Stall tracking: FSM follows the hazard, counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stallCntQ <= '0;
        end else begin
            case (state)
                RUN:     if (id_valid && hazard) state <= STALL;
                STALL:   if (!hazard)            state <= RUN;
                default: state <= RUN;
            endcase
            if (id_valid && hazard && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + CW'(1);
            end
        end
    end

    assign id_ready    = idReady;
    assign ex_valid    = exValidQ;
    assign ex_op1      = exQ.op1;
    assign ex_op2      = exQ.op2;
    assign ex_wreg     = exQ.wreg;
    assign ex_regwrite = exQ.regwrite;
    assign ex_memread  = exQ.memread;
    assign ex_fwd1     = exQ.fwd1;
    assign ex_fwd2     = exQ.fwd2;
    assign stall_cnt   = stallCntQ;

endmodule

// File: tb/tb_ex_fwd_stage.sv
// tb_ex_fwd_stage: bench for ex_fwd_stage (default CW plus a CW=2 copy for counter saturation).
// Latency: checks one-cycle capture after each transfer.
// Backpressure: drives random ex_ready and pending sources, compares against a reference model.
module tb_ex_fwd_stage;
    localparam int DW   = 32;
    localparam int NSRC = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, idValid, exReady, idRegwrite, idMemread;
    logic [AW-1:0] idRs, idRt, idWreg;
    logic [DW-1:0] idRsData, idRtData;
    logic          srcWe[NSRC];
    logic [AW-1:0] srcAddr[NSRC];
    logic [DW-1:0] srcData[NSRC];
    logic          srcPend[NSRC];

    logic [NSRC-1:0]    fwdWe, fwdPend;
    logic [NSRC*AW-1:0] fwdAddr;
    logic [NSRC*DW-1:0] fwdData;

    always_comb begin
        fwdWe = '0; fwdPend = '0; fwdAddr = '0; fwdData = '0;
        for (int i = 0; i < NSRC; i++) begin
            fwdWe[i]             = srcWe[i];
            fwdPend[i]           = srcPend[i];
            fwdAddr[i*AW +: AW]  = srcAddr[i];
            fwdData[i*DW +: DW]  = srcData[i];
        end
    end

    logic          idReady, exValid, exRw, exMr;
    logic [DW-1:0] exOp1, exOp2;
    logic [AW-1:0] exWreg;
    logic [2:0]    exF1, exF2;
    logic [15:0]   stallCnt;

    logic          satIdReady, satExValid, satRw, satMr;
    logic [DW-1:0] satOp1, satOp2;
    logic [AW-1:0] satWreg;
    logic [2:0]    satF1, satF2;
    logic [1:0]    satStallCnt;

    ex_fwd_stage #(.DW(DW), .NSRC(NSRC), .AW(AW), .CW(16)) dut (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_ready(idReady),
        .id_rs(idRs), .id_rt(idRt), .id_rs_data(idRsData), .id_rt_data(idRtData),
        .id_wreg(idWreg), .id_regwrite(idRegwrite), .id_memread(idMemread),
        .fwd_we(fwdWe), .fwd_addr(fwdAddr), .fwd_data(fwdData), .fwd_pend(fwdPend),
        .ex_valid(exValid), .ex_ready(exReady), .ex_op1(exOp1), .ex_op2(exOp2),
        .ex_wreg(exWreg), .ex_regwrite(exRw), .ex_memread(exMr),
        .ex_fwd1(exF1), .ex_fwd2(exF2), .stall_cnt(stallCnt)
    );

    ex_fwd_stage #(.DW(DW), .NSRC(NSRC), .AW(AW), .CW(2)) dutSat (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_ready(satIdReady),
        .id_rs(idRs), .id_rt(idRt), .id_rs_data(idRsData), .id_rt_data(idRtData),
        .id_wreg(idWreg), .id_regwrite(idRegwrite), .id_memread(idMemread),
        .fwd_we(fwdWe), .fwd_addr(fwdAddr), .fwd_data(fwdData), .fwd_pend(fwdPend),
        .ex_valid(satExValid), .ex_ready(exReady), .ex_op1(satOp1), .ex_op2(satOp2),
        .ex_wreg(satWreg), .ex_regwrite(satRw), .ex_memread(satMr),
        .ex_fwd1(satF1), .ex_fwd2(satF2), .stall_cnt(satStallCnt)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Reference model state
    bit            mValid;
    logic [DW-1:0] mOp1, mOp2;
    logic [AW-1:0] mWreg;
    logic          mRw, mMr;
    logic [2:0]    mF1, mF2;
    int            mCnt, mSat;
    logic          seenReady;

    // First matching source in priority order; register 0 never forwards.
    task automatic modelResolve(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                output logic [DW-1:0] d, output int sel, output bit pend);
        d = rf; sel = 0; pend = 0;
        if (a != 0) begin
            for (int i = 0; i < NSRC; i++) begin
                if (srcWe[i] && srcAddr[i] == a) begin
                    d = srcData[i]; sel = i + 1; pend = srcPend[i];
                    break;
                end
            end
        end
    endtask

    // One clock: check id_ready before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic [DW-1:0] d1, d2;
        int s1, s2;
        bit p1, p2, hz, ld, er, xf;
        modelResolve(idRs, idRsData, d1, s1, p1);
        modelResolve(idRt, idRtData, d2, s2, p2);
        hz = p1 | p2;
        ld = !mValid || exReady;
        er = ld && !hz && !rst;
        xf = idValid && er;
        #2;
        seenReady = idReady;
        check("id_ready", idReady, er);
        check("sat_id_ready", satIdReady, er);
        @(posedge clk);
        if (rst) begin
            mValid = 0; mOp1 = 0; mOp2 = 0; mWreg = 0; mRw = 0; mMr = 0;
            mF1 = 0; mF2 = 0; mCnt = 0; mSat = 0;
        end else begin
            if (idValid && hz) begin
                if (mCnt < 65535) mCnt++;
                if (mSat < 3) mSat++;
            end
            if (ld) begin
                mValid = xf;
                if (xf) begin
                    mOp1 = d1; mOp2 = d2; mWreg = idWreg; mRw = idRegwrite; mMr = idMemread;
                    mF1 = 3'(s1); mF2 = 3'(s2);
                end
            end
        end
        #1;
        check("ex_valid", exValid, mValid);
        check("ex_op1", exOp1, mOp1);
        check("ex_op2", exOp2, mOp2);
        check("ex_wreg", exWreg, mWreg);
        check("ex_regwrite", exRw, mRw);
        check("ex_memread", exMr, mMr);
        check("ex_fwd1", exF1, mF1);
        check("ex_fwd2", exF2, mF2);
        check("stall_cnt", stallCnt, mCnt);
        check("sat_stall_cnt", satStallCnt, mSat);
        check("sat_ex_valid", satExValid, mValid);
        check("sat_fields", {satOp1, satOp2, satWreg, satRw, satMr, satF1, satF2},
                            {mOp1, mOp2, mWreg, mRw, mMr, mF1, mF2});
    endtask

    task automatic clearSrc();
        for (int i = 0; i < NSRC; i++) begin
            srcWe[i] = 0; srcAddr[i] = 0; srcData[i] = 0; srcPend[i] = 0;
        end
    endtask

    task automatic resetPulse();
        rst = 1; idValid = 1; exReady = 1;
        step();
        check("rst_ready", seenReady, 0);
        check("rst_valid", exValid, 0);
        check("rst_ops", {exOp1, exOp2, exWreg, exRw, exMr, exF1, exF2}, 0);
        check("rst_cnt", stallCnt, 0);
        rst = 0; idValid = 0;
    endtask

    typedef struct {
        logic [AW-1:0] rs, rt;
        logic [DW-1:0] rsData, rtData;
        logic [1:0]    we;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    pend;
        logic [DW-1:0] expOp1, expOp2;
        logic [2:0]    expF1, expF2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd3, 5'd9, 32'h11111111, 32'h22222222, 2'b11, 5'd3, 5'd3, 32'hAAAA0000, 32'h00005555, 2'b00, 32'hAAAA0000, 32'h22222222, 3'd1, 3'd0};
        vecs[1] = '{5'd0, 5'd0, 32'h12345678, 32'h9ABCDEF0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hEEEEEEEE, 2'b00, 32'h12345678, 32'h9ABCDEF0, 3'd0, 3'd0};
        vecs[2] = '{5'd5, 5'd6, 32'h1, 32'h2, 2'b11, 5'd6, 5'd5, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b00, 32'hB1B1B1B1, 32'hA0A0A0A0, 3'd2, 3'd1};
        vecs[3] = '{5'd5, 5'd5, 32'h1, 32'h2, 2'b10, 5'd5, 5'd5, 32'h0000000C, 32'h0000000D, 2'b00, 32'h0000000D, 32'h0000000D, 3'd2, 3'd2};
        vecs[4] = '{5'd5, 5'd5, 32'h1, 32'h2, 2'b00, 5'd5, 5'd5, 32'h0000000C, 32'h0000000D, 2'b00, 32'h00000001, 32'h00000002, 3'd0, 3'd0};
        vecs[5] = '{5'd31, 5'd30, 32'h3, 32'h4, 2'b01, 5'd31, 5'd31, 32'hCAFEF00D, 32'h0BADBEEF, 2'b00, 32'hCAFEF00D, 32'h00000004, 3'd1, 3'd0};
        vecs[6] = '{5'd4, 5'd0, 32'h5, 32'h6, 2'b11, 5'd4, 5'd4, 32'h13579BDF, 32'h2468ACE0, 2'b10, 32'h13579BDF, 32'h00000006, 3'd1, 3'd0};

        rst = 1; idValid = 0; exReady = 1;
        idRs = 0; idRt = 0; idRsData = 0; idRtData = 0; idWreg = 0; idRegwrite = 0; idMemread = 0;
        clearSrc();
        mValid = 0; mOp1 = 0; mOp2 = 0; mWreg = 0; mRw = 0; mMr = 0; mF1 = 0; mF2 = 0;
        mCnt = 0; mSat = 0; seenReady = 0;
        @(posedge clk); #1;
        resetPulse();

        // Table-driven forwarding vectors, back to back with ex_ready high.
        for (int v = 0; v < 7; v++) begin
            idValid = 1; exReady = 1;
            idRs = vecs[v].rs; idRt = vecs[v].rt; idRsData = vecs[v].rsData; idRtData = vecs[v].rtData;
            idWreg = AW'(v + 1); idRegwrite = v[0]; idMemread = v[1];
            srcWe[0] = vecs[v].we[0]; srcWe[1] = vecs[v].we[1];
            srcAddr[0] = vecs[v].a0; srcAddr[1] = vecs[v].a1;
            srcData[0] = vecs[v].d0; srcData[1] = vecs[v].d1;
            srcPend[0] = vecs[v].pend[0]; srcPend[1] = vecs[v].pend[1];
            step();
            check($sformatf("vec%0d_ready", v), seenReady, 1);
            check($sformatf("vec%0d_valid", v), exValid, 1);
            check($sformatf("vec%0d_op1", v), exOp1, vecs[v].expOp1);
            check($sformatf("vec%0d_op2", v), exOp2, vecs[v].expOp2);
            check($sformatf("vec%0d_fwd1", v), exF1, vecs[v].expF1);
            check($sformatf("vec%0d_fwd2", v), exF2, vecs[v].expF2);
        end

        // Load-use stall on rt for two cycles, then capture.
        clearSrc(); resetPulse();
        idValid = 1; exReady = 1; idRs = 0; idRt = 7; idRsData = 32'h66; idRtData = 32'h77;
        srcWe[0] = 1; srcAddr[0] = 7; srcData[0] = 32'hDEADBEEF; srcPend[0] = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("pend_ready", seenReady, 0);
            check("pend_valid", exValid, 0);
        end
        check("pend_cnt", stallCnt, 2);
        srcPend[0] = 0;
        step();
        check("pend_done_ready", seenReady, 1);
        check("pend_done_valid", exValid, 1);
        check("pend_done_op2", exOp2, 32'hDEADBEEF);
        check("pend_done_fwd2", exF2, 1);
        check("pend_done_cnt", stallCnt, 2);

        // Downstream backpressure holds the output register.
        clearSrc();
        exReady = 0; idValid = 1; idRs = 2; idRsData = 32'h2222; idRt = 0; idRtData = 32'h3333;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_ready", seenReady, 0);
            check("bp_valid", exValid, 1);
            check("bp_op2", exOp2, 32'hDEADBEEF);
            check("bp_fwd2", exF2, 1);
        end
        exReady = 1;
        step();
        check("bp_release_ready", seenReady, 1);
        check("bp_release_op1", exOp1, 32'h2222);
        check("bp_release_op2", exOp2, 32'h3333);
        check("bp_release_fwd2", exF2, 0);

        // Counter saturation on the CW=2 copy.
        resetPulse();
        idValid = 1; exReady = 1; idRs = 9; idRsData = 32'h9;
        srcWe[0] = 1; srcAddr[0] = 9; srcData[0] = 32'h99990000; srcPend[0] = 1;
        for (int c = 0; c < 5; c++) step();
        check("sat_cnt5", satStallCnt, 3);
        check("wide_cnt5", stallCnt, 5);
        step();
        check("sat_cnt6", satStallCnt, 3);

        // Reset while stalled drops the held instruction and clears the counter.
        rst = 1;
        step();
        check("midrst_ready", seenReady, 0);
        check("midrst_valid", exValid, 0);
        check("midrst_cnt", stallCnt, 0);
        check("midrst_sat", satStallCnt, 0);
        rst = 0; srcPend[0] = 0;
        step();
        check("postrst_ready", seenReady, 1);
        check("postrst_op1", exOp1, 32'h99990000);
        check("postrst_fwd1", exF1, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            idValid = ($urandom_range(0, 3) != 0);
            exReady = ($urandom_range(0, 3) != 0);
            idRs = AW'($urandom_range(0, 7)); idRt = AW'($urandom_range(0, 7));
            idRsData = $urandom; idRtData = $urandom;
            idWreg = AW'($urandom); idRegwrite = 1'($urandom); idMemread = 1'($urandom);
            for (int i = 0; i < NSRC; i++) begin
                srcWe[i] = ($urandom_range(0, 3) != 0);
                srcAddr[i] = AW'($urandom_range(0, 7));
                srcData[i] = $urandom;
                srcPend[i] = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
